// File: rtl/acc_dct_mc.sv
// Multi-channel signed accumulator for DCT term sums: each channel sums NTERM
// signed samples and emits one rounded, saturated result per completed sum.
module acc_dct_mc #(
  parameter int unsigned IN_W  = 23,
  parameter int unsigned GUARD = 5,
  parameter int unsigned NCH   = 8,
  parameter int unsigned NTERM = 8,
  parameter int unsigned RSH   = 0,
  parameter int unsigned OUT_W = 28,
  localparam int unsigned ACC_W = IN_W + GUARD,
  localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             sub,
  input  logic             new1,
  input  logic             clr,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(NTERM + 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic [CNT_W-1:0]        cnt_q [NCH];
  logic [CNT_W-1:0]        cnt_d [NCH];
  logic                    ovf_q, ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;

  logic                    ch_ok;
  logic                    take;
  logic                    start;
  logic                    wrap_ovf;
  logic                    done;
  logic signed [ACC_W-1:0] cur_acc;
  logic [CNT_W-1:0]        cur_cnt;
  logic signed [ACC_W-1:0] samp;
  logic signed [ACC_W-1:0] add_res;
  logic signed [ACC_W-1:0] new_acc;
  logic [CNT_W-1:0]        new_cnt;
  logic signed [ACC_W:0]   ext_acc;
  logic signed [ACC_W:0]   rnd_acc;
  logic [OUT_W-1:0]        sat_acc;

  // Selected-channel datapath: load or add/subtract the incoming sample
  always_comb begin
    ch_ok   = (32'(in_ch) < NCH);
    take    = in_valid && ch_ok && !clr;
    cur_acc = '0;
    cur_cnt = '0;
    if (ch_ok) begin
      cur_acc = acc_q[in_ch];
      cur_cnt = cnt_q[in_ch];
    end
    samp     = ACC_W'($signed(in_data));
    start    = new1 || (cur_cnt == '0);
    add_res  = sub ? (cur_acc - samp) : (cur_acc + samp);
    wrap_ovf = (sub ? (cur_acc[ACC_W-1] != samp[ACC_W-1])
                    : (cur_acc[ACC_W-1] == samp[ACC_W-1]))
               && (add_res[ACC_W-1] != cur_acc[ACC_W-1]);
    new_acc  = start ? samp : add_res;
    new_cnt  = start ? CNT_W'(1) : (cur_cnt + CNT_W'(1));
    done     = (new_cnt == CNT_W'(NTERM));
  end

  assign ext_acc = (ACC_W + 1)'(new_acc);

  // Round-half-up shift, done one bit wider so the bias cannot wrap
  generate
    if (RSH > 0) begin : g_round
      localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (RSH - 1);
      assign rnd_acc = $signed(ext_acc + HALF) >>> RSH;
    end else begin : g_pass
      assign rnd_acc = ext_acc;
    end
  endgenerate

  always_comb begin
    if (rnd_acc > SAT_MAX) begin
      sat_acc = SAT_MAX[OUT_W-1:0];
    end else if (rnd_acc < SAT_MIN) begin
      sat_acc = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_acc = rnd_acc[OUT_W-1:0];
    end
  end

  // Next-state: clear beats samples; a completing channel rearms to zero terms
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
      ovf_d = 1'b0;
    end else if (take) begin
      acc_d[in_ch] = new_acc;
      cnt_d[in_ch] = done ? '0 : new_cnt;
      if (!start && wrap_ovf) begin
        ovf_d = 1'b1;
      end
      if (done) begin
        out_valid_d = 1'b1;
        out_data_d  = sat_acc;
        out_ch_d    = in_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign ovf       = ovf_q;

endmodule
